puf_ram_loader: RTL
===================

// Module: puf_ram_loader
// PURPOSE
//  UART-to-SRAM writer; the write-side counterpart of the PUF byte readout path. Waits for host
//  command 'w' (0x77), receives PUF_BYTES bytes, packs byte pairs into 16-bit words and writes
//  them to combined_ram (low byte = even byte index), then returns one status byte to the host.
//  Used to preload known patterns before a PUF readout. Sits between the UART core and the RAM write port.
// PARAMETERS
//  PUF_BYTES       16384    bytes per load; even; <= 2*2**ADDR_W
//  ADDR_W          13       RAM word-address width
//  TIMEOUT_CYCLES  1200000  max clk cycles between received bytes during a load (100 ms @ 12 MHz)
// PORTS
//  clk               in   1       system clock
//  rst               in   1       asynchronous reset, active-high
//  uart_rx_ready     in   1       1-cycle pulse: uart_data_from_rx valid this cycle
//  uart_data_from_rx in   8       received byte
//  uart_tx_ready     in   1       UART transmitter idle
//  uart_data_to_tx   out  8       status byte to transmit
//  uart_tx_enable    out  1       1-cycle pulse: start transmission
//  ram_waddr         out  ADDR_W  RAM word write address
//  ram_wdata         out  16      RAM write data {high byte, low byte}
//  ram_wmask         out  16      RAM bit write mask; constant 0 (all 16 bits written)
//  ram_we            out  1       RAM write enable, 1-cycle pulse
//  busy              out  1       high in every state except IDLE
//  load_ok           out  1       sticky: last load completed; cleared on next 'w' or rst
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte/word counters, timeout counter, low-byte register cleared.
//  States / transitions (all registered):
//   IDLE:       rx pulse with data 0x77 -> RX_LOW, word_idx=0, clear load_ok+timeout; other bytes ignored.
//   RX_LOW:     rx pulse -> latch byte as low byte, reset timeout, -> RX_HIGH.
//   RX_HIGH:    rx pulse -> register {data, low}, reset timeout, -> WRITE.
//   WRITE:      ram_we=1 exactly this cycle, ram_waddr=word_idx, ram_wdata=registered word.
//               If word_idx == PUF_BYTES/2-1 -> ACK_READY with status 0x6B ('k'); else word_idx+1 -> RX_LOW.
//   ACK_READY:  wait uart_tx_ready==1 -> ACK_SEND.
//   ACK_SEND:   uart_tx_enable=1 one cycle; uart_data_to_tx held stable from ACK_READY until
//               ACK_DONE exits -> ACK_BUSY.
//   ACK_BUSY:   wait uart_tx_ready==0 -> ACK_DONE.
//   ACK_DONE:   wait uart_tx_ready==1 -> IDLE; set load_ok iff status was 'k'.
//  Latency: ram_we asserts the cycle after the rx pulse carrying the high byte.
//  Timeout: counter runs only in RX_LOW/RX_HIGH; reaching TIMEOUT_CYCLES -> ACK_READY with status
//   0x65 ('e'); a pending low byte is discarded (never written); words already written stay.
//  Bytes received outside IDLE/RX_LOW/RX_HIGH are dropped; 0x77 during a load is plain data.
//  word_idx never wraps: last word is PUF_BYTES/2-1; ram_waddr outside WRITE holds last value.
//  ram_wmask tied 0; ram_we never high outside WRITE; uart_tx_enable never high outside ACK_SEND.
//  Reset mid-load or mid-ack: immediate return to IDLE, no further writes or tx pulses.
// TESTING
//  1 PUF_BYTES=8: send 0x77,01..08 -> ram_we 4x, waddr 0..3, wdata 0201,0403,0605,0807; tx 0x6B; load_ok=1.
//  2 Send 0x41,0x00 then 0x77 + 8 bytes -> first two bytes ignored; writes exactly as scenario 1.
//  3 TIMEOUT_CYCLES=100: 0x77,AA,BB,CC, then idle 100 cycles -> one write (waddr0=BBAA); tx 0x65; load_ok=0.
//  4 Hold uart_tx_ready=0 at completion for 50 cycles -> no tx_enable until ready=1, then single 1-cycle pulse.
//  5 Assert rst after 3rd data byte -> outputs 0, state IDLE; new 0x77 load restarts at waddr 0.
//  6 0x77 inside payload (byte 3 = 0x77) -> stored as data: waddr1 = 0x0477.

Source files
------------

// File: rtl/puf_ram_loader_if.sv
// UART and RAM write-port bundle for puf_ram_loader.
// The master side is the loader; the slave side is the UART core / RAM / status environment.
interface puf_ram_loader_if #(
    parameter int unsigned ADDR_W = 13
) ();
    logic              uart_rx_ready;
    logic [7:0]        uart_data_from_rx;
    logic              uart_tx_ready;
    logic [7:0]        uart_data_to_tx;
    logic              uart_tx_enable;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_wmask;
    logic              ram_we;
    logic              busy;
    logic              load_ok;

    modport master (
        input  uart_rx_ready, uart_data_from_rx, uart_tx_ready,
        output uart_data_to_tx, uart_tx_enable, ram_waddr, ram_wdata, ram_wmask, ram_we,
               busy, load_ok
    );

    modport slave (
        output uart_rx_ready, uart_data_from_rx, uart_tx_ready,
        input  uart_data_to_tx, uart_tx_enable, ram_waddr, ram_wdata, ram_wmask, ram_we,
               busy, load_ok
    );
endinterface

// File: rtl/puf_ram_loader.sv
// UART-to-SRAM loader: after command 'w' receives PUF_BYTES bytes, writes them as 16-bit
// words (low byte first) and answers the host with one status byte ('k' ok, 'e' timeout).
module puf_ram_loader #(
    parameter int unsigned PUF_BYTES      = 16384,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input logic                clk,
    input logic                rst,
    puf_ram_loader_if.master   bus
);
    localparam int unsigned       TmoW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LastWord  = ADDR_W'(PUF_BYTES / 2 - 1);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        CmdWrite  = 8'h77;
    localparam logic [7:0]        StatusOk  = 8'h6B;
    localparam logic [7:0]        StatusErr = 8'h65;

    typedef enum logic [2:0] {
        StIdle, StRxLow, StRxHigh, StWrite, StAckReady, StAckSend, StAckBusy, StAckDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        low_q, low_d;
    logic [7:0]        status_q, status_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              load_ok_q, load_ok_d;

    logic rx, rx_cmd, tmo_hit, last_word;

    assign rx        = bus.uart_rx_ready;
    assign rx_cmd    = rx && (bus.uart_data_from_rx == CmdWrite);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit   = (tmo_q == TmoLast) && !rx;
    assign last_word = (word_idx_q == LastWord);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            word_idx_q <= '0;
            waddr_q    <= '0;
            word_q     <= '0;
            low_q      <= '0;
            status_q   <= '0;
            tmo_q      <= '0;
            load_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            waddr_q    <= waddr_d;
            word_q     <= word_d;
            low_q      <= low_d;
            status_q   <= status_d;
            tmo_q      <= tmo_d;
            load_ok_q  <= load_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (rx_cmd) state_d = StRxLow;
            StRxLow: begin
                if (rx)           state_d = StRxHigh;
                else if (tmo_hit) state_d = StAckReady;
            end
            StRxHigh: begin
                if (rx)           state_d = StWrite;
                else if (tmo_hit) state_d = StAckReady;
            end
            StWrite:    state_d = last_word ? StAckReady : StRxLow;
            StAckReady: if (bus.uart_tx_ready) state_d = StAckSend;
            StAckSend:  state_d = StAckBusy;
            StAckBusy:  if (!bus.uart_tx_ready) state_d = StAckDone;
            StAckDone:  if (bus.uart_tx_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        word_idx_d = word_idx_q;
        waddr_d    = waddr_q;
        word_d     = word_q;
        low_d      = low_q;
        status_d   = status_q;
        tmo_d      = '0;
        load_ok_d  = load_ok_q;
        unique case (state_q)
            StIdle: begin
                if (rx_cmd) begin
                    word_idx_d = '0;
                    load_ok_d  = 1'b0;
                end
            end
            StRxLow, StRxHigh: begin
                tmo_d = rx ? '0 : tmo_q + TmoW'(1);
                if (rx && state_q == StRxLow) begin
                    low_d = bus.uart_data_from_rx;
                end else if (rx) begin
                    word_d  = {bus.uart_data_from_rx, low_q};
                    waddr_d = word_idx_q;
                end else if (tmo_hit) begin
                    status_d = StatusErr;
                end
            end
            StWrite: begin
                if (last_word) status_d   = StatusOk;
                else           word_idx_d = word_idx_q + ADDR_W'(1);
            end
            StAckDone: begin
                if (bus.uart_tx_ready) load_ok_d = (status_q == StatusOk);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.ram_we          = (state_q == StWrite);
        bus.uart_tx_enable  = (state_q == StAckSend);
        bus.busy            = (state_q != StIdle);
        bus.ram_waddr       = waddr_q;
        bus.ram_wdata       = word_q;
        bus.ram_wmask       = '0;
        bus.uart_data_to_tx = status_q;
        bus.load_ok         = load_ok_q;
    end
endmodule
